// File: rtl/enduro_axis_pkg.sv
// -----------------------------------------------------------------------------
// enduro_axis_pkg
// Shared types and helpers for the enduro AXI4-Stream traffic generator and
// the matching stream checker.
//   gen_state_e        generator FSM states
//   LFSR_POLY_DEFAULT  Galois feedback mask x^32+x^22+x^2+x+1
//   lfsr_next()        one Galois LFSR step, width-agnostic up to LFSR_MAX_W
// -----------------------------------------------------------------------------
package enduro_axis_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } gen_state_e;

   localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8020_0003;
   localparam int          LFSR_MAX_W        = 64;

   // Callers zero-extend to LFSR_MAX_W and truncate the result back; the
   // zero upper bits keep the shift correct for any narrower register.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] x,
                                                     input logic [LFSR_MAX_W-1:0] poly);
      return (x >> 1) ^ (x[0] ? poly : '0);
   endfunction

endpackage

// File: rtl/enduro_lfsr.sv
// -----------------------------------------------------------------------------
// enduro_lfsr
// Galois LFSR holding the current beat data.
//   m_axis_clk      clock
//   m_axis_aresetn  synchronous active-low reset (q clears to 0)
//   load            load seed (has priority over advance)
//   seed            value loaded on load
//   advance         step once
//   q               current LFSR value
// -----------------------------------------------------------------------------
module enduro_lfsr
   import enduro_axis_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] POLY       = LFSR_POLY_DEFAULT
) (
   input  logic                  m_axis_clk,
   input  logic                  m_axis_aresetn,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic                  advance,
   output logic [DATA_WIDTH-1:0] q
);

   always_ff @(posedge m_axis_clk) begin
      if (!m_axis_aresetn) begin
         q <= '0;
      end else if (load) begin
         q <= seed;
      end else if (advance) begin
         q <= DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(q), LFSR_MAX_W'(POLY)));
      end
   end

endmodule

// File: rtl/enduro_axis_stream_gen.sv
// -----------------------------------------------------------------------------
// enduro_axis_stream_gen
// AXI4-Stream master traffic generator. After a start pulse in IDLE it emits
// cfg_count beats of Galois-LFSR data seeded by cfg_seed (0 is replaced by 1),
// inserts cfg_gap idle cycles after each non-final beat, marks the final beat
// with tlast and pulses done for one cycle.
//   m_axis_clk, m_axis_aresetn   clock, synchronous active-low reset
//   start, cfg_count/gap/seed    run request and its configuration
//   m_axis_tvalid/tready/tdata/tlast  AXI4-Stream master port
//   busy, done, beat_cnt          status
// Optional: define ENDURO_AXIS_GEN_STALL_CNT_EN to add stall_cnt[31:0], the
// saturating count of tvalid&&!tready cycles in the current run.
// -----------------------------------------------------------------------------
module enduro_axis_stream_gen
   import enduro_axis_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    CNT_WIDTH  = 16,
   parameter int                    GAP_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = LFSR_POLY_DEFAULT
) (
   input  logic                  m_axis_clk,
   input  logic                  m_axis_aresetn,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  cfg_count,
   input  logic [GAP_WIDTH-1:0]  cfg_gap,
   input  logic [DATA_WIDTH-1:0] cfg_seed,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  beat_cnt
`ifdef ENDURO_AXIS_GEN_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cnt
`endif
);

   gen_state_e            state, state_nxt;
   logic [CNT_WIDTH-1:0]  count_q;
   logic [GAP_WIDTH-1:0]  gap_q;
   logic [GAP_WIDTH-1:0]  gap_cnt;
   logic                  start_acc;
   logic                  xfer;
   logic                  last_beat;
   logic                  enter_gap;
   logic [DATA_WIDTH-1:0] seed_fix;

   assign start_acc = (state == IDLE) && start;
   assign xfer      = m_axis_tvalid && m_axis_tready;
   // count_q >= 1 whenever SEND is reachable, so count-1 never underflows
   // and the full CNT_WIDTH range needs no extra compare bit.
   assign last_beat = (beat_cnt == count_q - CNT_WIDTH'(1));
   assign enter_gap = xfer && !last_beat && (gap_q != '0);
   // An all-zero seed would lock the LFSR at zero.
   assign seed_fix  = (cfg_seed == '0) ? DATA_WIDTH'(1) : cfg_seed;

   assign m_axis_tvalid = (state == SEND);
   assign m_axis_tlast  = (state == SEND) && last_beat;
   assign busy          = (state != IDLE);
   assign done          = (state == FIN);

   enduro_lfsr #(
      .DATA_WIDTH (DATA_WIDTH),
      .POLY       (LFSR_POLY)
   ) u_lfsr (
      .m_axis_clk     (m_axis_clk),
      .m_axis_aresetn (m_axis_aresetn),
      .load           (start_acc),
      .seed           (seed_fix),
      .advance        (xfer),
      .q              (m_axis_tdata)
   );

   always_ff @(posedge m_axis_clk) begin
      if (!m_axis_aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (cfg_count == '0) ? FIN : SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (last_beat) begin
                  state_nxt = FIN;
               end else if (gap_q != '0) begin
                  state_nxt = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               state_nxt = SEND;
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge m_axis_clk) begin
      if (!m_axis_aresetn) begin
         count_q  <= '0;
         gap_q    <= '0;
         gap_cnt  <= '0;
         beat_cnt <= '0;
      end else begin
         if (start_acc) begin
            count_q  <= cfg_count;
            gap_q    <= cfg_gap;
            beat_cnt <= '0;
         end else if (xfer) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
         end
         // Loaded with gap-1 so GAP lasts exactly gap_q cycles.
         if (enter_gap) begin
            gap_cnt <= gap_q - GAP_WIDTH'(1);
         end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
         end
      end
   end

`ifdef ENDURO_AXIS_GEN_STALL_CNT_EN
   always_ff @(posedge m_axis_clk) begin
      if (!m_axis_aresetn) begin
         stall_cnt <= '0;
      end else if (start_acc) begin
         stall_cnt <= '0;
      end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_enduro_axis_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_enduro_axis_stream_gen
// Self-checking bench for enduro_axis_stream_gen: table of directed runs,
// hand-written reset / boundary sequences and randomized runs, all checked
// against a beat-level reference model of the generator.
// -----------------------------------------------------------------------------
module tb_enduro_axis_stream_gen;

   localparam int          DW   = 32;
   localparam int          CW   = 16;
   localparam int          GW   = 8;
   localparam logic [31:0] POLY = 32'h8020_0003;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_count = '0;
   logic [GW-1:0] cfg_gap = '0;
   logic [DW-1:0] cfg_seed = '0;
   logic          tvalid;
   logic          tready = 1'b0;
   logic [DW-1:0] tdata;
   logic          tlast;
   logic          busy;
   logic          done;
   logic [CW-1:0] beat_cnt;
`ifdef ENDURO_AXIS_GEN_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   always #5 clk = ~clk;

   enduro_axis_stream_gen dut (
      .m_axis_clk     (clk),
      .m_axis_aresetn (aresetn),
      .start          (start),
      .cfg_count      (cfg_count),
      .cfg_gap        (cfg_gap),
      .cfg_seed       (cfg_seed),
      .m_axis_tvalid  (tvalid),
      .m_axis_tready  (tready),
      .m_axis_tdata   (tdata),
      .m_axis_tlast   (tlast),
      .busy           (busy),
      .done           (done),
      .beat_cnt       (beat_cnt)
`ifdef ENDURO_AXIS_GEN_STALL_CNT_EN
      ,
      .stall_cnt      (stall_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference LFSR step straight from the polynomial definition.
   function automatic logic [31:0] model_step(input logic [31:0] x);
      return (x >> 1) ^ (((x % 2) == 1) ? POLY : 32'h0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Results of the last run()
   int          r_beats, r_dones, r_done_cyc, r_last_xfer, r_tlasts, r_stalls;
   logic [31:0] r_first, r_lastdata;

   // mode: 0 tready=1, 1 random tready, 2 tready low 5 cycles on beat 1
   // poke: 0 none, 1 start pulse at cycle 2 (busy), 2 start pulse in the done cycle
   task automatic run(input logic [31:0] seed, input int count, input int gap,
                      input int mode, input int poke, input string tag);
      logic [31:0] exp_x;
      logic [31:0] prev_d;
      logic        prev_v, prev_l, prev_stall;
      int          cyc, stall_run, post;
      exp_x = (seed == 32'h0) ? 32'h1 : seed;
      r_beats = 0; r_dones = 0; r_done_cyc = -1; r_last_xfer = 0;
      r_tlasts = 0; r_stalls = 0; r_first = '0; r_lastdata = '0;
      cfg_seed  = seed;
      cfg_count = CW'(count);
      cfg_gap   = GW'(gap);
      start     = 1'b1;
      tready    = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " busy after start"}, busy, 1);
      cyc = 1; stall_run = 0; post = -1;
      prev_v = 1'b0; prev_l = 1'b0; prev_stall = 1'b0; prev_d = '0;
      while (cyc < 3000 && post < 4) begin
         case (mode)
            0:       tready = 1'b1;
            1:       tready = ($urandom_range(0, 3) != 0);
            default: tready = !(r_beats == 1 && stall_run < 5);
         endcase
         start = 1'b0;
         if (poke == 1 && cyc == 2) begin
            start = 1'b1; cfg_count = 16'd3; cfg_seed = 32'h1234;
         end
         if (poke == 2 && done) start = 1'b1;
         if (prev_stall) begin
            chk({tag, " hold tvalid"}, tvalid, 1);
            chk({tag, " hold tdata"}, tdata, prev_d);
            chk({tag, " hold tlast"}, tlast, prev_l);
         end
         if (done) begin
            r_dones++;
            r_done_cyc = cyc;
            if (post < 0) post = 0;
         end
         if (post > 0) chk({tag, " idle after done"}, {tvalid, busy, done}, 0);
         if (tvalid && post < 0) begin
            if (!prev_v && r_beats > 0) chk({tag, " gap length"}, cyc - r_last_xfer - 1, gap);
            chk({tag, " tlast"}, tlast, (r_beats == count - 1));
            if (tready) begin
               chk({tag, " tdata"}, tdata, exp_x);
               exp_x = model_step(exp_x);
               if (r_beats == 0) r_first = tdata;
               r_lastdata = tdata;
               if (tlast) r_tlasts++;
               r_beats++;
               r_last_xfer = cyc;
            end else begin
               r_stalls++;
               if (mode == 2) stall_run++;
            end
         end
         prev_v = tvalid; prev_stall = tvalid && !tready; prev_d = tdata; prev_l = tlast;
         tick();
         cyc++;
         if (post >= 0) post++;
      end
      start = 1'b0;
      chk({tag, " beats"}, r_beats, count);
      chk({tag, " done pulses"}, r_dones, 1);
      chk({tag, " done timing"}, r_done_cyc, (count == 0) ? 1 : r_last_xfer + 1);
      chk({tag, " tlast count"}, r_tlasts, (count > 0) ? 1 : 0);
      chk({tag, " beat_cnt"}, beat_cnt, count);
`ifdef ENDURO_AXIS_GEN_STALL_CNT_EN
      chk({tag, " stall_cnt"}, stall_cnt, r_stalls);
`endif
   endtask

   typedef struct {
      logic [31:0] seed;
      int          count;
      int          gap;
      logic [31:0] first;
      logic [31:0] lastd;
      int          done_cyc;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{32'h0000_0001, 4, 0, 32'h0000_0001, 32'h6018_0001, 5};
      vt[1] = '{32'h0000_0001, 3, 2, 32'h0000_0001, 32'hC030_0002, 8};
      vt[2] = '{32'h0000_0000, 2, 0, 32'h0000_0001, 32'h8020_0003, 3};
      vt[3] = '{32'h8020_0003, 2, 1, 32'h8020_0003, 32'hC030_0002, 4};
      vt[4] = '{32'h0000_0005, 0, 3, 32'h0000_0000, 32'h0000_0000, 1};
      vt[5] = '{32'hC030_0002, 1, 5, 32'hC030_0002, 32'hC030_0002, 2};

      // Reset state
      aresetn = 1'b0;
      repeat (3) tick();
      chk("reset tvalid", tvalid, 0);
      chk("reset tlast", tlast, 0);
      chk("reset tdata", tdata, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset beat_cnt", beat_cnt, 0);
`ifdef ENDURO_AXIS_GEN_STALL_CNT_EN
      chk("reset stall_cnt", stall_cnt, 0);
`endif
      aresetn = 1'b1;
      tick();

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run(vt[i].seed, vt[i].count, vt[i].gap, 0, 0, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d first", i), r_first, vt[i].first);
         chk($sformatf("vec%0d last", i), r_lastdata, vt[i].lastd);
         chk($sformatf("vec%0d done cycle", i), r_done_cyc, vt[i].done_cyc);
         tick();
      end

      // Backpressure on beat 1
      run(32'h1, 3, 0, 2, 0, "bp");
      chk("bp stall cycles", r_stalls, 5);
      tick();

      // start while busy, and start in the done cycle
      run(32'h1, 5, 0, 0, 1, "busy_start");
      run(32'h1, 2, 1, 0, 2, "fin_start");
      tick();

      // Reset mid-run after beat 2 of 10
      cfg_seed = 32'h1; cfg_count = 16'd10; cfg_gap = '0; tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      aresetn = 1'b0;
      tick();
      chk("midreset tvalid", tvalid, 0);
      chk("midreset busy", busy, 0);
      chk("midreset beat_cnt", beat_cnt, 0);
      chk("midreset done", done, 0);
      aresetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("after reset quiet", {tvalid, done, busy}, 0);
      end
      run(32'h1, 3, 1, 0, 0, "post_reset");
      tick();

      // Maximum count: no premature tlast
      cfg_seed = 32'h7; cfg_count = 16'hFFFF; cfg_gap = '0; tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("maxcnt tvalid", tvalid, 1);
         chk("maxcnt tlast", tlast, 0);
         tick();
      end
      chk("maxcnt beat_cnt", beat_cnt, 3);
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      tick();

      // Randomized runs
      for (int i = 0; i < 15; i++) begin
         logic [31:0] s;
         s = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
         run(s, $urandom_range(0, 20), $urandom_range(0, 4), 1, 0, $sformatf("rnd%0d", i));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
